// File: rtl/softmc_pkg.sv
// Shared definitions for the instruction sequence receiver:
// end-marker opcode, opcode field position, lane index width helper.
package softmc_pkg;

  localparam logic [3:0] ISEQ_END = 4'h0;

  localparam int INSTR_OP_MSB = 31;
  localparam int INSTR_OP_LSB = 28;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_WAIT_BUSY
  } issue_state_t;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iseq_receiver_mc_lane_fifo.sv
// lane_fifo: synchronous first-word-fall-through FIFO for one lane.
// Ports: clk, rst_n, wr_en/din, rd_en/dout, full, empty.
module lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit tells a full FIFO from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign dout = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/iseq_receiver_mc.sv
// Instruction sequence receiver: arbitrates app/maint sources, spreads a
// sequence round-robin over lane FIFOs, queues and issues whole sequences.
// Ports: app_*/maint_* sources, dispatcher_ready/process_iseq handover,
// lane_rd_en/lane_dout/lane_empty lanes, iq_full, pending_seqs, rx_busy.
module iseq_receiver_mc
  import softmc_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int LANE_DEPTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int MAX_SEQS    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             app_en,
  input  logic [INSTR_WIDTH-1:0]           app_instr,
  output logic                             app_ack,
  input  logic                             maint_en,
  input  logic [INSTR_WIDTH-1:0]           maint_instr,
  output logic                             maint_ack,
  input  logic                             dispatcher_ready,
  output logic                             process_iseq,
  input  logic [NUM_LANES-1:0]             lane_rd_en,
  output logic [NUM_LANES*INSTR_WIDTH-1:0] lane_dout,
  output logic [NUM_LANES-1:0]             lane_empty,
  output logic                             iq_full,
  output logic [2:0]                       pending_seqs,
  output logic                             rx_busy
);

  localparam int LW = lane_idx_w(NUM_LANES);

  logic [LW-1:0]          lane_ptr;
  logic                   lock_maint;
  logic [NUM_LANES-1:0]   lane_full;
  logic [NUM_LANES-1:0]   lane_wr;
  logic                   sel_maint;
  logic                   sel_en;
  logic [INSTR_WIDTH-1:0] sel_instr;
  logic                   is_end;
  logic                   has_space;
  logic                   has_room;
  logic                   accept;
  logic                   end_inc;
  logic                   issue;
  logic                   ptr_last;
  issue_state_t           state;
  issue_state_t           state_nxt;

  // While a sequence is open the locked source is the only candidate;
  // otherwise maint has priority over app.
  assign sel_maint = rx_busy ? lock_maint : maint_en;
  assign sel_en    = sel_maint ? maint_en : app_en;
  assign sel_instr = sel_maint ? maint_instr : app_instr;

  assign is_end = (sel_instr[INSTR_OP_MSB:INSTR_OP_LSB] == ISEQ_END);

  // Registered full flag only: a same-cycle pop does not open the lane.
  assign has_space = is_end || !lane_full[lane_ptr];
  // A new sequence may start only while the pending queue has room.
  assign has_room  = rx_busy || (pending_seqs < 3'(MAX_SEQS));

  assign accept    = rst_n && sel_en && has_space && has_room;
  assign maint_ack = accept && sel_maint;
  assign app_ack   = accept && !sel_maint;

  assign end_inc  = accept && is_end && rx_busy;
  assign ptr_last = (lane_ptr == LW'(NUM_LANES - 1));

  assign iq_full = |lane_full;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_wr[i] = accept && !is_end && (lane_ptr == LW'(i));

    lane_fifo #(
      .WIDTH (INSTR_WIDTH),
      .DEPTH (LANE_DEPTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (lane_wr[i]),
      .din   (sel_instr),
      .rd_en (lane_rd_en[i]),
      .dout  (lane_dout[i*INSTR_WIDTH +: INSTR_WIDTH]),
      .full  (lane_full[i]),
      .empty (lane_empty[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy    <= 1'b0;
      lock_maint <= 1'b0;
      lane_ptr   <= '0;
    end else if (accept) begin
      if (is_end) begin
        rx_busy  <= 1'b0;
        lane_ptr <= '0;
      end else begin
        rx_busy    <= 1'b1;
        lock_maint <= sel_maint;
        lane_ptr   <= ptr_last ? '0 : lane_ptr + 1'b1;
      end
    end
  end

  // One pulse per dispatcher run: after issuing, wait for the
  // dispatcher to drop ready before another sequence may go.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      ISSUE_IDLE: begin
        if ((pending_seqs != 3'd0) && dispatcher_ready) begin
          issue     = 1'b1;
          state_nxt = ISSUE_WAIT_BUSY;
        end
      end
      ISSUE_WAIT_BUSY: begin
        if (!dispatcher_ready) state_nxt = ISSUE_IDLE;
      end
      default: state_nxt = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ISSUE_IDLE;
      process_iseq <= 1'b0;
      pending_seqs <= 3'd0;
    end else begin
      state        <= state_nxt;
      process_iseq <= issue;
      pending_seqs <= pending_seqs + {2'b00, end_inc} - {2'b00, issue};
    end
  end

endmodule

// File: tb/tb_iseq_receiver_mc.sv
// Directed bench for iseq_receiver_mc: a two-lane instance for sequencing
// and arbitration, a one-lane depth-4 instance for lane-full behaviour.
module tb_iseq_receiver_mc;
  import softmc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        app_en, maint_en, rdy;
  logic [31:0] app_instr, maint_instr;
  logic        app_ack, maint_ack, proc_iseq, iq_full, busy;
  logic [1:0]  rd_en, empty;
  logic [63:0] dout;
  logic [2:0]  pend;

  logic        b_app_en, b_maint_en, b_rdy;
  logic [31:0] b_app_instr, b_maint_instr, b_dout;
  logic        b_app_ack, b_maint_ack, b_proc, b_iq_full, b_busy;
  logic [0:0]  b_rd_en, b_empty;
  logic [2:0]  b_pend;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iseq_receiver_mc #(
    .NUM_LANES(2), .LANE_DEPTH(8), .INSTR_WIDTH(32), .MAX_SEQS(2)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .app_en(app_en), .app_instr(app_instr), .app_ack(app_ack),
    .maint_en(maint_en), .maint_instr(maint_instr), .maint_ack(maint_ack),
    .dispatcher_ready(rdy), .process_iseq(proc_iseq),
    .lane_rd_en(rd_en), .lane_dout(dout), .lane_empty(empty),
    .iq_full(iq_full), .pending_seqs(pend), .rx_busy(busy)
  );

  iseq_receiver_mc #(
    .NUM_LANES(1), .LANE_DEPTH(4), .INSTR_WIDTH(32), .MAX_SEQS(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .app_en(b_app_en), .app_instr(b_app_instr), .app_ack(b_app_ack),
    .maint_en(b_maint_en), .maint_instr(b_maint_instr),
    .maint_ack(b_maint_ack),
    .dispatcher_ready(b_rdy), .process_iseq(b_proc),
    .lane_rd_en(b_rd_en), .lane_dout(b_dout), .lane_empty(b_empty),
    .iq_full(b_iq_full), .pending_seqs(b_pend), .rx_busy(b_busy)
  );

  function automatic logic [31:0] ins(input int k);
    return {4'h1, 28'(k)};
  endfunction

  function automatic logic [31:0] endm();
    return {ISEQ_END, 28'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic app_put(input logic [31:0] v, input logic exp,
                         input string tag);
    app_en = 1'b1;
    app_instr = v;
    #1 chk(tag, 64'(app_ack), 64'(exp));
    step();
    app_en = 1'b0;
  endtask

  task automatic maint_put(input logic [31:0] v, input string tag);
    maint_en = 1'b1;
    maint_instr = v;
    #1;
    chk({tag, "_mack"}, 64'(maint_ack), 64'd1);
    chk({tag, "_aack"}, 64'(app_ack), 64'd0);
    step();
    maint_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    app_en = 0; maint_en = 0; rdy = 0; rd_en = 0;
    app_instr = 0; maint_instr = 0;
    b_app_en = 0; b_maint_en = 0; b_rdy = 0; b_rd_en = 0;
    b_app_instr = 0; b_maint_instr = 0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("rst_empty", 64'(empty), 64'h3);
    chk("rst_pend", 64'(pend), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_proc", 64'(proc_iseq), 64'd0);
    chk("rst_iqfull", 64'(iq_full), 64'd0);
    chk("rst_b_empty", 64'(b_empty), 64'h1);

    // Reset in the middle of a sequence
    app_put(ins(100), 1'b1, "t1_ack0");
    app_put(ins(101), 1'b1, "t1_ack1");
    app_put(ins(102), 1'b1, "t1_ack2");
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_empty", 64'(empty), 64'h0);
    app_en = 1'b1;
    app_instr = ins(103);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_ack", 64'(app_ack), 64'd0);
    chk("t1_rst_empty", 64'(empty), 64'h3);
    chk("t1_rst_busy", 64'(busy), 64'd0);
    chk("t1_rst_pend", 64'(pend), 64'd0);
    chk("t1_rst_iqfull", 64'(iq_full), 64'd0);
    app_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Round-robin over two lanes, one issue
    rdy = 1'b1;
    for (int k = 0; k < 5; k++) app_put(ins(k), 1'b1, "t2_ack");
    app_put(endm(), 1'b1, "t2_end_ack");
    chk("t2_pend1", 64'(pend), 64'd1);
    chk("t2_proc0", 64'(proc_iseq), 64'd0);
    chk("t2_busy", 64'(busy), 64'd0);
    step();
    chk("t2_pulse", 64'(proc_iseq), 64'd1);
    chk("t2_pend0", 64'(pend), 64'd0);
    step();
    chk("t2_pulse_end", 64'(proc_iseq), 64'd0);
    rdy = 1'b0;
    chk("t2_l0_h0", 64'(dout[31:0]), 64'(ins(0)));
    chk("t2_l1_h0", 64'(dout[63:32]), 64'(ins(1)));
    rd_en = 2'b11;
    step();
    chk("t2_l0_h1", 64'(dout[31:0]), 64'(ins(2)));
    chk("t2_l1_h1", 64'(dout[63:32]), 64'(ins(3)));
    step();
    chk("t2_l0_h2", 64'(dout[31:0]), 64'(ins(4)));
    chk("t2_empty_l1", 64'(empty), 64'h2);
    step();
    chk("t2_empty_all", 64'(empty), 64'h3);
    step();
    chk("t2_pop_empty", 64'(empty), 64'h3);
    rd_en = 2'b00;

    // Maint wins while idle and holds the lock until its END
    app_en = 1'b1;
    app_instr = ins(50);
    maint_put(ins(60), "t3_m0");
    maint_en = 1'b1;
    maint_put(ins(61), "t3_m1");
    maint_en = 1'b1;
    maint_put(endm(), "t3_mend");
    #1 chk("t3_app_ack", 64'(app_ack), 64'd1);
    step();
    app_put(endm(), 1'b1, "t3_aend");
    chk("t3_l0", 64'(dout[31:0]), 64'(ins(60)));
    chk("t3_l1", 64'(dout[63:32]), 64'(ins(61)));

    // Two sequences queued: a third cannot start
    chk("t4_pend2", 64'(pend), 64'd2);
    app_en = 1'b1;
    app_instr = ins(70);
    #1 chk("t4_stall", 64'(app_ack), 64'd0);
    app_en = 1'b0;
    rdy = 1'b1;
    step();
    chk("t4_pulse1", 64'(proc_iseq), 64'd1);
    chk("t4_pend1", 64'(pend), 64'd1);
    step();
    chk("t4_no_repeat", 64'(proc_iseq), 64'd0);
    chk("t4_pend_hold", 64'(pend), 64'd1);
    rdy = 1'b0;
    step();
    rdy = 1'b1;
    step();
    chk("t4_pulse2", 64'(proc_iseq), 64'd1);
    chk("t4_pend0", 64'(pend), 64'd0);
    rdy = 1'b0;
    app_put(ins(70), 1'b1, "t4_third");
    app_put(ins(71), 1'b1, "t4_third1");
    app_put(endm(), 1'b1, "t4_third_end");
    chk("t4_pend_third", 64'(pend), 64'd1);

    // END accepted on the same edge as an issue
    app_put(ins(80), 1'b1, "t6_y0");
    app_en = 1'b1;
    app_instr = endm();
    rdy = 1'b1;
    #1 chk("t6_end_ack", 64'(app_ack), 64'd1);
    step();
    app_en = 1'b0;
    chk("t6_same_pend", 64'(pend), 64'd1);
    chk("t6_same_pulse", 64'(proc_iseq), 64'd1);
    rdy = 1'b0;
    step();
    rdy = 1'b1;
    step();
    chk("t6_drain_pend", 64'(pend), 64'd0);
    rdy = 1'b0;
    step();
    // Empty sequence: acked and dropped
    app_put(endm(), 1'b1, "t6_lone_end");
    chk("t6_lone_pend", 64'(pend), 64'd0);
    chk("t6_lone_busy", 64'(busy), 64'd0);
    rdy = 1'b1;
    step();
    chk("t6_lone_nopulse", 64'(proc_iseq), 64'd0);
    rdy = 1'b0;

    // One lane, depth 4: fifth instruction waits for a pop
    b_app_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_app_instr = ins(200 + k);
      #1 chk("t5_ack", 64'(b_app_ack), 64'd1);
      step();
    end
    b_app_instr = ins(204);
    #1;
    chk("t5_full_nack", 64'(b_app_ack), 64'd0);
    chk("t5_iqfull", 64'(b_iq_full), 64'd1);
    chk("t5_busy", 64'(b_busy), 64'd1);
    b_rd_en = 1'b1;
    #1 chk("t5_no_bypass", 64'(b_app_ack), 64'd0);
    step();
    b_rd_en = 1'b0;
    #1;
    chk("t5_resume", 64'(b_app_ack), 64'd1);
    chk("t5_iqfull_clr", 64'(b_iq_full), 64'd0);
    step();
    b_app_en = 1'b0;
    chk("t5_head", 64'(b_dout), 64'(ins(201)));
    chk("t5_refull", 64'(b_iq_full), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
